// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master mock and its slave model.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // Value of the R/W bit that follows the address.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [3:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_ADDR_ACK,
    M_WDATA,
    M_WACK,
    M_RDATA,
    M_RNACK,
    M_STOP
  } master_state_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WDATA    = 3'd3,
    S_WACK     = 3'd4,
    S_RDATA    = 3'd5,
    S_RACK     = 3'd6
  } slave_state_t;

endpackage

// File: rtl/i2c_slave_model.sv
// Byte-register I2C slave clocked purely by bus edges (no clock, no reset).
// START/STOP are detected by toggle flags on sda edges; the scl-rising
// process acknowledges them, so every register has exactly one writer.
module i2c_slave_model
  import i2c_pkg::*;
(
  inout  wire               sda,
  input  logic              scl,
  input  logic [ADDR_W-1:0] my_addr,
  output logic [DATA_W-1:0] curr_data,
  output logic [ADDR_W-1:0] rcvd_addr,
  output logic              rcvd_mode,
  output logic [2:0]        state
);

  logic              start_tog   = 1'b0;
  logic              start_ack   = 1'b0;
  logic              stop_tog    = 1'b0;
  logic              stop_ack    = 1'b0;
  slave_state_t      core_state  = S_IDLE;
  logic [2:0]        bit_cnt     = 3'd0;
  logic [ADDR_W-1:0] shift       = '0;
  logic [DATA_W-1:0] curr_data_q = '0;
  logic [ADDR_W-1:0] rcvd_addr_q = '0;
  logic              rcvd_mode_q = 1'b0;
  logic              drive_low   = 1'b0;

  logic start_pend;
  logic stop_pend;

  assign start_pend = (start_tog != start_ack);
  assign stop_pend  = (stop_tog != stop_ack);

  // A pending START wins over a pending STOP (STOP then START before any scl).
  assign state = start_pend ? S_ADDR : (stop_pend ? S_IDLE : core_state);

  assign curr_data = curr_data_q;
  assign rcvd_addr = rcvd_addr_q;
  assign rcvd_mode = rcvd_mode_q;

  // Pending START/STOP release the line at once, without waiting for scl.
  assign sda = (drive_low && !start_pend && !stop_pend) ? 1'b0 : 1'bz;

  // START: sda falls while scl is high.
  always_ff @(negedge sda) begin
    if (scl) start_tog <= ~start_tog;
  end

  // STOP: sda rises while scl is high.
  always_ff @(posedge sda) begin
    if (scl) stop_tog <= ~stop_tog;
  end

  // Sample the bus and advance the protocol on every scl rising edge.
  always_ff @(posedge scl) begin
    start_ack <= start_tog;
    stop_ack  <= stop_tog;
    if (start_pend) begin
      core_state <= S_ADDR;
      shift      <= {{(ADDR_W-1){1'b0}}, sda};
      bit_cnt    <= 3'd1;
    end else if (stop_pend) begin
      core_state <= S_IDLE;
      bit_cnt    <= 3'd0;
    end else begin
      case (core_state)
        S_ADDR: begin
          if (bit_cnt == 3'd7) begin
            rcvd_addr_q <= shift;
            rcvd_mode_q <= sda;
            core_state  <= (shift == my_addr) ? S_ADDR_ACK : S_IDLE;
            bit_cnt     <= 3'd0;
          end else begin
            shift   <= {shift[ADDR_W-2:0], sda};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_ADDR_ACK: begin
          core_state <= (rcvd_mode_q == RW_READ) ? S_RDATA : S_WDATA;
          bit_cnt    <= 3'd0;
        end
        S_WDATA: begin
          if (bit_cnt == 3'd7) begin
            curr_data_q <= {shift, sda};
            core_state  <= S_WACK;
            bit_cnt     <= 3'd0;
          end else begin
            shift   <= {shift[ADDR_W-2:0], sda};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_WACK: begin
          core_state <= S_WDATA;
          bit_cnt    <= 3'd0;
        end
        S_RDATA: begin
          if (bit_cnt == 3'd7) begin
            core_state <= S_RACK;
            bit_cnt    <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_RACK: begin
          core_state <= sda ? S_IDLE : S_RDATA;
          bit_cnt    <= 3'd0;
        end
        default: begin
          core_state <= S_IDLE;
          bit_cnt    <= 3'd0;
        end
      endcase
    end
  end

  // Update what the slave drives while scl is low.
  always_ff @(negedge scl) begin
    case (core_state)
      S_ADDR_ACK, S_WACK: drive_low <= 1'b1;
      S_RDATA:            drive_low <= ~curr_data_q[3'd7 - bit_cnt];
      default:            drive_low <= 1'b0;
    endcase
  end

endmodule

// File: rtl/i2c_master_mock.sv
// Single-byte I2C master with a start/ready host handshake.
// Each bit is four quarter-phases of QCLKS clocks; all bus outputs are
// registered and change on the edge that enters a quarter.
module i2c_master_mock
  import i2c_pkg::*;
#(
  parameter int QCLKS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              error,
  inout  wire               sda,
  output logic              scl
);

  localparam int DIV_W = (QCLKS > 1) ? $clog2(QCLKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QCLKS - 1);

  master_state_t     state;
  logic [1:0]        quarter;
  logic [DIV_W-1:0]  div;
  logic [2:0]        bit_cnt;
  logic [7:0]        tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] data_lat;
  logic              is_read;
  logic              nack;
  logic              sample;
  logic              sda_low;

  // Open drain: only ever pull low.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Transaction sequencer: quarter-phase timing, bit shifting and handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= M_IDLE;
      quarter   <= 2'd0;
      div       <= '0;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= '0;
      data_lat  <= '0;
      is_read   <= 1'b0;
      nack      <= 1'b0;
      sample    <= 1'b1;
      sda_low   <= 1'b0;
      scl       <= 1'b1;
      ready     <= 1'b1;
      error     <= 1'b0;
      read_data <= '0;
    end else if (state == M_IDLE) begin
      div     <= '0;
      quarter <= 2'd0;
      bit_cnt <= 3'd0;
      if (start) begin
        tx_shift <= {address, (write ? RW_WRITE : RW_READ)};
        data_lat <= write_data;
        is_read  <= ~write;
        nack     <= 1'b0;
        error    <= 1'b0;
        ready    <= 1'b0;
        state    <= M_START;
      end
    end else if (div != DIV_LAST) begin
      div <= div + 1'b1;
    end else begin
      div <= '0;
      case (quarter)
        2'd0: quarter <= 2'd1;
        2'd1: begin
          quarter <= 2'd2;
          scl     <= 1'b1;
          if (state == M_START) sda_low <= 1'b1;
        end
        2'd2: begin
          quarter <= 2'd3;
          sample  <= sda;
          if (state == M_RDATA) rx_shift <= {rx_shift[DATA_W-2:0], sda};
          if (state == M_STOP) sda_low <= 1'b0;
        end
        default: begin
          quarter <= 2'd0;
          scl     <= 1'b0;
          case (state)
            M_START: begin
              state   <= M_ADDR;
              bit_cnt <= 3'd0;
              sda_low <= ~tx_shift[7];
            end
            M_ADDR, M_WDATA: begin
              if (bit_cnt == 3'd7) begin
                state   <= (state == M_ADDR) ? M_ADDR_ACK : M_WACK;
                sda_low <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                tx_shift <= {tx_shift[6:0], 1'b0};
                sda_low  <= ~tx_shift[6];
              end
            end
            M_ADDR_ACK: begin
              bit_cnt <= 3'd0;
              if (sample) begin
                nack    <= 1'b1;
                state   <= M_STOP;
                sda_low <= 1'b1;
              end else if (is_read) begin
                state   <= M_RDATA;
                sda_low <= 1'b0;
              end else begin
                state    <= M_WDATA;
                tx_shift <= data_lat;
                sda_low  <= ~data_lat[DATA_W-1];
              end
            end
            M_WACK: begin
              if (sample) nack <= 1'b1;
              state   <= M_STOP;
              sda_low <= 1'b1;
            end
            M_RDATA: begin
              if (bit_cnt == 3'd7) begin
                state <= M_RNACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
              sda_low <= 1'b0;
            end
            M_RNACK: begin
              state   <= M_STOP;
              sda_low <= 1'b1;
            end
            M_STOP: begin
              state   <= M_IDLE;
              scl     <= 1'b1;
              sda_low <= 1'b0;
              ready   <= 1'b1;
              error   <= nack;
              if (is_read) read_data <= rx_shift;
            end
            default: begin
              state   <= M_IDLE;
              scl     <= 1'b1;
              sda_low <= 1'b0;
              ready   <= 1'b1;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_mock.sv
// Directed bench: one master and four byte-register slaves (addresses 80..83)
// on a pulled-up sda line.
module tb_i2c_master_mock;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       write = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic [6:0] address = 7'd0;
  logic [7:0] read_data;
  logic       ready;
  logic       error;
  logic       scl;
  wire        sda;

  logic [7:0] slv_data  [4];
  logic [6:0] slv_raddr [4];
  logic       slv_rmode [4];
  logic [2:0] slv_state [4];

  int checks = 0;
  int errors = 0;
  int stop_seen = 0;

  pullup (sda);

  i2c_master_mock #(.QCLKS(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .write      (write),
    .write_data (write_data),
    .address    (address),
    .read_data  (read_data),
    .ready      (ready),
    .error      (error),
    .sda        (sda),
    .scl        (scl)
  );

  for (genvar g = 0; g < 4; g++) begin : g_slave
    i2c_slave_model u_slave (
      .sda       (sda),
      .scl       (scl),
      .my_addr   (7'(80 + g)),
      .curr_data (slv_data[g]),
      .rcvd_addr (slv_raddr[g]),
      .rcvd_mode (slv_rmode[g]),
      .state     (slv_state[g])
    );
  end

  always #5 clock = ~clock;

  // Count STOP conditions seen on the bus.
  always @(posedge sda) begin
    if (scl) stop_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One transaction; inputs are scrambled after the start cycle, and with
  // poke set a stray start is pulsed while the master is busy.
  task automatic applyStimulus(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                               input bit poke, input string tag);
    int cyc;
    @(negedge clock);
    start = 1'b1; write = wr; address = addr; write_data = data;
    @(negedge clock);
    start = 1'b0; write = ~wr; address = 7'h7F; write_data = ~data;
    checkOutput({tag, " busy"}, 32'(ready), 32'd0);
    cyc = 1;
    while (!ready && cyc < 100) begin
      if (poke && cyc == 30) begin
        start = 1'b1; write = 1'b1; address = 7'd83; write_data = 8'hEE;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    checkOutput({tag, " done"}, 32'(ready), 32'd1);
    checkOutput({tag, " latency<=90"}, 32'(cyc <= 90), 32'd1);
  endtask

  initial begin
    int stops_before;

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("rst ready", 32'(ready), 32'd1);
    checkOutput("rst error", 32'(error), 32'd0);
    checkOutput("rst read_data", 32'(read_data), 32'h00);
    checkOutput("rst scl", 32'(scl), 32'd1);
    checkOutput("rst sda", 32'(sda), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Writes to three slaves.
    applyStimulus(1'b1, 7'd80, 8'h21, 1'b0, "wr80");
    checkOutput("wr80 error", 32'(error), 32'd0);
    checkOutput("wr80 data80", 32'(slv_data[0]), 32'h21);
    checkOutput("wr80 data81", 32'(slv_data[1]), 32'h00);
    applyStimulus(1'b1, 7'd81, 8'h56, 1'b0, "wr81");
    checkOutput("wr81 error", 32'(error), 32'd0);
    checkOutput("wr81 data81", 32'(slv_data[1]), 32'h56);
    checkOutput("wr81 data80", 32'(slv_data[0]), 32'h21);
    applyStimulus(1'b1, 7'd82, 8'h18, 1'b0, "wr82");
    checkOutput("wr82 error", 32'(error), 32'd0);
    checkOutput("wr82 data82", 32'(slv_data[2]), 32'h18);
    checkOutput("wr82 data83", 32'(slv_data[3]), 32'h00);

    // Reads.
    applyStimulus(1'b0, 7'd83, 8'h00, 1'b0, "rd83");
    checkOutput("rd83 read_data", 32'(read_data), 32'h00);
    checkOutput("rd83 error", 32'(error), 32'd0);
    checkOutput("rd83 rcvd_mode", 32'(slv_rmode[3]), 32'd1);
    checkOutput("rd83 rcvd_addr", 32'(slv_raddr[3]), 32'd83);
    applyStimulus(1'b0, 7'd80, 8'h00, 1'b0, "rd80");
    checkOutput("rd80 read_data", 32'(read_data), 32'h21);
    checkOutput("rd80 error", 32'(error), 32'd0);
    applyStimulus(1'b0, 7'd81, 8'h00, 1'b0, "rd81");
    checkOutput("rd81 read_data", 32'(read_data), 32'h56);
    checkOutput("rd81 error", 32'(error), 32'd0);

    // Write to an absent address.
    stops_before = stop_seen;
    applyStimulus(1'b1, 7'h10, 8'hAA, 1'b0, "wr10");
    checkOutput("wr10 error", 32'(error), 32'd1);
    checkOutput("wr10 data80", 32'(slv_data[0]), 32'h21);
    checkOutput("wr10 data81", 32'(slv_data[1]), 32'h56);
    checkOutput("wr10 data82", 32'(slv_data[2]), 32'h18);
    checkOutput("wr10 data83", 32'(slv_data[3]), 32'h00);
    checkOutput("wr10 stop", 32'(stop_seen - stops_before), 32'd1);
    checkOutput("wr10 sda", 32'(sda), 32'd1);
    checkOutput("wr10 scl", 32'(scl), 32'd1);

    // Reset in the middle of the address phase.
    @(negedge clock);
    start = 1'b1; write = 1'b1; address = 7'd80; write_data = 8'h77;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    checkOutput("abort busy", 32'(ready), 32'd0);
    stops_before = stop_seen;
    reset = 1'b0;
    #1;
    checkOutput("abort ready", 32'(ready), 32'd1);
    checkOutput("abort scl", 32'(scl), 32'd1);
    checkOutput("abort sda", 32'(sda), 32'd1);
    checkOutput("abort error", 32'(error), 32'd0);
    checkOutput("abort read_data", 32'(read_data), 32'h00);
    repeat (2) @(negedge clock);
    checkOutput("abort no stop", 32'(stop_seen - stops_before), 32'd0);
    checkOutput("abort data80", 32'(slv_data[0]), 32'h21);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, 7'd80, 8'h33, 1'b0, "wr80b");
    checkOutput("wr80b error", 32'(error), 32'd0);
    checkOutput("wr80b data80", 32'(slv_data[0]), 32'h33);

    // Stray start while busy must be ignored.
    applyStimulus(1'b1, 7'd82, 8'h5A, 1'b1, "poke");
    checkOutput("poke error", 32'(error), 32'd0);
    checkOutput("poke data82", 32'(slv_data[2]), 32'h5A);
    checkOutput("poke data83", 32'(slv_data[3]), 32'h00);
    repeat (10) @(negedge clock);
    checkOutput("poke stays idle", 32'(ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_mock.md
Name: i2c_master_mock

Overview:
- Single-byte I2C bus master, driven by a simple start/ready handshake.
- One transaction = START, 7-bit address + R/W, ACK, one data byte (written to or read from the slave), ACK/NACK, STOP.
- Sits between a host and a shared open-drain SDA line (pulled up). Addressable byte-register slaves share the line.
- A slave model ships alongside the master, so master and slaves are verified as one subsystem.

Parameters:
- QCLKS, default 1: clock cycles per SCL quarter-phase. One bit lasts 4*QCLKS clocks.

Ports:
- clock  in  1  system clock; all master logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle transaction request; honoured only while ready=1.
- write  in  1  1 = write transaction, 0 = read transaction; latched on start.
- write_data  in  8  byte to send; latched on start.
- address  in  7  target slave address; latched on start.
- read_data  out  8  byte received in a read transaction; valid when ready rises.
- ready  out  1  1 = idle, accepts start.
- error  out  1  1 = the last transaction saw a NACK.
- sda  inout  1  open-drain: drives 0 or high-Z, never 1.
- scl  out  1  push-pull bus clock; idles high.

Behaviour:
- Reset (asserted): master goes to IDLE.
  - ready=1, error=0, read_data=8'h00.
  - scl=1, sda released.
  - A reset mid-transaction aborts the transaction immediately; no STOP is generated.
- Start acceptance: start=1 and ready=1 on a clock edge.
  - address, write and write_data are latched.
  - error clears to 0 and ready goes to 0 on that same edge.
  - start while ready=0 is ignored.
- Bit timing: each bit is 4 quarter-phases.
  - q0: scl low; master updates sda.
  - q1: scl low.
  - q2: scl high; master samples sda.
  - q3: scl high.
  - sda changes only while scl is low, except at START and STOP.
- Master states: IDLE → START → ADDR → ADDR_ACK → (WDATA → WACK | RDATA → RNACK) → STOP → IDLE.
  - START: sda falls while scl is high.
  - ADDR: sends address[6:0] then the R/W bit (1 = read), 8 bits, MSB first.
  - ADDR_ACK: sda released; sampled 0 means ACK.
  - WDATA: sends write_data, MSB first; WACK samples the slave ACK.
  - RDATA: sda released; shifts in 8 bits, MSB first.
  - RNACK: master leaves sda released, i.e. sends NACK.
  - STOP: sda rises while scl is high.
- NACK at ADDR_ACK: error=1, skip the data phase, go to STOP.
- NACK at WACK: error=1.
- Completion: read_data (read transactions only) and error update on the edge where ready returns to 1, after STOP.
  - Total latency from start to ready with QCLKS=1 is at most 90 clocks.
- Slave (sub-module) behaviour:
  - Clocked only by scl/sda edges; it has no clock or reset.
  - curr_data powers up at 8'h00, and state at IDLE.
  - A START (sda falling while scl is high), in any state, forces state ADDR and clears the bit count.
  - A STOP (sda rising while scl is high) forces IDLE and releases sda.
  - The slave samples on scl rising and drives on scl falling.
  - After 8 address bits: rcvd_addr and rcvd_mode (1 = read) update. If rcvd_addr == my_addr, the slave pulls sda low for the ACK bit; otherwise it returns to IDLE and stays silent until the next START.
  - Write: shifts in 8 bits, stores them to curr_data after the 8th bit, then ACKs.
  - Read: drives curr_data MSB first, then releases sda for the master's ACK/NACK; goes to IDLE on NACK.
  - Slave state encoding (3 bits): 0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WDATA, 4 WACK, 5 RDATA, 6 RACK.

Decomposition:
- Shared package i2c_pkg holds:
  - master state enum;
  - slave state enum (3-bit encoding above);
  - constants RW_READ=1 and RW_WRITE=0;
  - ADDR_W=7 and DATA_W=8.
- One sub-module, i2c_slave_model, with ports:
  - sda inout 1, scl in 1, my_addr in 7;
  - curr_data out 8, rcvd_addr out 7, rcvd_mode out 1, state out 3.
- A test harness connects one master and four slaves, at addresses 80–83, on a pulled-up sda.

Test Plan:
- Write 8'h21 to address 80, 8'h56 to 81, 8'h18 to 82, each with a 1-cycle start → ready rises within 100 clocks; error=0; each slave's curr_data equals the sent byte; the other slaves are unchanged.
- Read address 83 (never written) → read_data=8'h00, error=0, slave 83 rcvd_mode=1.
- Read address 80 after writing 8'h21, then read 81 → read_data=8'h21, then 8'h56; error=0.
- Write 8'hAA to address 7'h10 (no slave) → error=1; every curr_data unchanged; STOP is seen (sda high, scl high) and ready=1.
- Assert reset mid-address phase → ready=1, scl=1, sda released, error=0. A following write of 8'h33 to address 80 succeeds.
- Pulse start while ready=0 → ignored; the transaction in flight completes with its original latched address and data.
